// File: rtl/inst_rom_loader_if.sv
// Byte-stream input and instruction-RAM write port of the boot loader.
// master = host / byte source side, slave = inst_rom_loader.
interface inst_rom_loader_if #(
  parameter int ADDR_WIDTH = 32
);
  logic [7:0]            in_data;
  logic                  in_valid;
  logic                  in_ready;
  logic                  ram_we;
  logic [ADDR_WIDTH-1:0] ram_waddr;
  logic [31:0]           ram_wdata;

  modport master (
    output in_data, in_valid,
    input  in_ready, ram_we, ram_waddr, ram_wdata
  );

  modport slave (
    input  in_data, in_valid,
    output in_ready, ram_we, ram_waddr, ram_wdata
  );
endinterface

// File: rtl/inst_rom_loader.sv
// Boot-time instruction RAM writer: little-endian byte stream -> 32-bit word writes,
// holding the core in reset until loaded. Define LOADER_CHECKSUM_EN for a trailing checksum.
module inst_rom_loader #(
  parameter int          ADDR_WIDTH = 32,
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
  parameter int          MAX_WORDS  = 1024,
  parameter int          CNT_WIDTH  = 11
) (
  input  logic                 clk,
  input  logic                 rst,
  inst_rom_loader_if.slave     bus,
  output logic                 core_hold,
  output logic                 load_done,
  output logic                 load_err,
  output logic [CNT_WIDTH-1:0] word_cnt
);

  typedef enum logic [2:0] {
    S_LEN,
    S_DATA,
`ifdef LOADER_CHECKSUM_EN
    S_SUM,
`endif
    S_DONE,
    S_ERR
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] BASE_A  = ADDR_WIDTH'(BASE_ADDR);
  localparam logic [31:0]           MAX_W32 = 32'(MAX_WORDS);

  state_t               state;
  logic [1:0]           lane;
  logic [23:0]          byte_buf;
  logic [CNT_WIDTH-1:0] n_words;
  logic [31:0]          word_full;
  logic                 accept;
  logic                 word_done;
`ifdef LOADER_CHECKSUM_EN
  logic [31:0]          sum_acc;
`endif

  // Gated by rst so nothing is accepted while the block is held in reset.
`ifdef LOADER_CHECKSUM_EN
  assign bus.in_ready = rst && (state == S_LEN || state == S_DATA || state == S_SUM);
`else
  assign bus.in_ready = rst && (state == S_LEN || state == S_DATA);
`endif

  assign accept    = bus.in_valid && bus.in_ready;
  assign word_done = accept && (lane == 2'd3);
  assign word_full = {bus.in_data, byte_buf};

  always_ff @(posedge clk) begin
    if (!rst) begin
      state         <= S_LEN;
      lane          <= 2'd0;
      byte_buf      <= 24'd0;
      n_words       <= '0;
      bus.ram_we    <= 1'b0;
      bus.ram_waddr <= BASE_A;
      bus.ram_wdata <= 32'd0;
      core_hold     <= 1'b1;
      load_done     <= 1'b0;
      load_err      <= 1'b0;
      word_cnt      <= '0;
`ifdef LOADER_CHECKSUM_EN
      sum_acc       <= 32'd0;
`endif
    end else begin
      bus.ram_we <= 1'b0;
      if (accept) begin
        lane <= lane + 2'd1;
        case (lane)
          2'd0:    byte_buf[7:0]   <= bus.in_data;
          2'd1:    byte_buf[15:8]  <= bus.in_data;
          2'd2:    byte_buf[23:16] <= bus.in_data;
          default: ;
        endcase
      end
      if (word_done) begin
        case (state)
          S_LEN: begin
            if (word_full == 32'd0) begin
`ifdef LOADER_CHECKSUM_EN
              state     <= S_SUM;
`else
              state     <= S_DONE;
              load_done <= 1'b1;
              core_hold <= 1'b0;
`endif
            end else if (word_full > MAX_W32) begin
              state    <= S_ERR;
              load_err <= 1'b1;
            end else begin
              state    <= S_DATA;
              n_words  <= word_full[CNT_WIDTH-1:0];
              word_cnt <= '0;
            end
          end
          S_DATA: begin
            // Strobe registers at the same edge as the 4th byte: one-cycle latency.
            bus.ram_we    <= 1'b1;
            bus.ram_waddr <= BASE_A + (ADDR_WIDTH'(word_cnt) << 2);
            bus.ram_wdata <= word_full;
            word_cnt      <= word_cnt + 1'b1;
`ifdef LOADER_CHECKSUM_EN
            sum_acc       <= sum_acc + word_full;
`endif
            if (word_cnt == n_words - 1'b1) begin
`ifdef LOADER_CHECKSUM_EN
              state     <= S_SUM;
`else
              state     <= S_DONE;
              load_done <= 1'b1;
              core_hold <= 1'b0;
`endif
            end
          end
`ifdef LOADER_CHECKSUM_EN
          S_SUM: begin
            if (word_full == sum_acc) begin
              state     <= S_DONE;
              load_done <= 1'b1;
              core_hold <= 1'b0;
            end else begin
              state    <= S_ERR;
              load_err <= 1'b1;
            end
          end
`endif
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_inst_rom_loader.sv
// Scoreboard bench for inst_rom_loader: expected writes queued as bytes are driven,
// compared against writes captured from the RAM port.
module tb_inst_rom_loader;

  localparam int          AW   = 32;
  localparam logic [31:0] BASE = 32'h1000_0000;
  localparam int          MAXW = 1024;
  localparam int          CW   = 11;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic [31:0] cyc;
  } wr_t;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          core_hold;
  logic          load_done;
  logic          load_err;
  logic [CW-1:0] word_cnt;
  logic [31:0]   cyc = 32'd0;

  int checks = 0;
  int errors = 0;

  wr_t         exp_q[$];
  wr_t         obs_q[$];
  logic [7:0]  tx_q[$];
  logic [31:0] img_w[$];

  inst_rom_loader_if #(.ADDR_WIDTH(AW)) bus ();

  inst_rom_loader #(
    .ADDR_WIDTH(AW),
    .BASE_ADDR (BASE),
    .MAX_WORDS (MAXW),
    .CNT_WIDTH (CW)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .core_hold(core_hold),
    .load_done(load_done),
    .load_err (load_err),
    .word_cnt (word_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 32'd1;

  // Capture every strobe with the cycle it was seen in.
  always @(negedge clk) begin : monitor
    wr_t w;
    if (bus.ram_we === 1'b1) begin
      w.addr = bus.ram_waddr;
      w.data = bus.ram_wdata;
      w.cyc  = cyc;
      obs_q.push_back(w);
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog expired got running want finished");
    $fatal(1, "[TB] watchdog");
  end

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = 8'd0;
    @(posedge clk);
    @(negedge clk);
    exp_q.delete();
    obs_q.delete();
    rst = 1'b1;
  endtask

  task automatic build_image(input logic [31:0] n_hdr, input logic [31:0] sum_delta);
    logic [31:0] s;
    tx_q.delete();
    s = sum_delta;
    for (int i = 0; i < 4; i++) tx_q.push_back(n_hdr[8*i +: 8]);
    foreach (img_w[w]) begin
      for (int i = 0; i < 4; i++) tx_q.push_back(img_w[w][8*i +: 8]);
      s = s + img_w[w];
    end
`ifdef LOADER_CHECKSUM_EN
    for (int i = 0; i < 4; i++) tx_q.push_back(s[8*i +: 8]);
`endif
  endtask

  // Ends right after the posedge of the last handshake.
  task automatic send_bytes(input int limit, input int gap_max, input int n_writes);
    int          gaps;
    int          waitc;
    int          accepted;
    int          w;
    bit          hs;
    logic [31:0] c;
    wr_t         e;
    c = 32'd0;
    foreach (tx_q[j]) begin
      if (j >= limit) break;
      gaps = $urandom_range(gap_max, 0);
      repeat (gaps) begin
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.in_data  = 8'($urandom);
        @(posedge clk);
      end
      hs    = 1'b0;
      waitc = 0;
      while (!hs && waitc < 50) begin
        @(negedge clk);
        bus.in_data  = tx_q[j];
        bus.in_valid = 1'b1;
        hs = (bus.in_ready === 1'b1);
        c  = cyc;
        @(posedge clk);
        waitc++;
      end
      if (!hs) begin
        checks++;
        errors++;
        $display("[TB] FAIL byte_accept_timeout byte %0d got not accepted want accepted", j);
        return;
      end
      accepted = j + 1;
      w = accepted / 4 - 2;
      if (accepted > 4 && accepted % 4 == 0 && w < n_writes) begin
        e.addr = BASE + 32'(4 * w);
        e.data = img_w[w];
        e.cyc  = c + 32'd1;
        exp_q.push_back(e);
      end
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_data  = 8'hFF;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (bus.in_ready !== 1'b0 || bus.ram_we !== 1'b0 || core_hold !== 1'b1 ||
        load_done !== 1'b0 || load_err !== 1'b0 || word_cnt !== '0) begin
      errors++;
      $display("[TB] FAIL reset_ctrl got rdy=%b we=%b hold=%b done=%b err=%b cnt=%0d want 0 0 1 0 0 0",
               bus.in_ready, bus.ram_we, core_hold, load_done, load_err, word_cnt);
    end
    checks++;
    if (bus.ram_waddr !== BASE || bus.ram_wdata !== 32'd0) begin
      errors++;
      $display("[TB] FAIL reset_bus got addr=%h data=%h want addr=%h data=0",
               bus.ram_waddr, bus.ram_wdata, BASE);
    end
    bus.in_valid = 1'b0;
    rst = 1'b1;
    #1;
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL reset_release_ready got %b want 1", bus.in_ready);
    end
  endtask

  task automatic test_basic();
    apply_reset();
    img_w = '{32'h0000_0013, 32'h0010_0093};
    build_image(32'd2, 32'd0);
    send_bytes(tx_q.size(), 0, 2);
    @(negedge clk);
    bus.in_valid = 1'b0;
    checks++;
    if (bus.in_ready !== 1'b0 || load_done !== 1'b1 || core_hold !== 1'b0 ||
        load_err !== 1'b0 || word_cnt !== CW'(2)) begin
      errors++;
      $display("[TB] FAIL basic_status got rdy=%b done=%b hold=%b err=%b cnt=%0d want 0 1 0 0 2",
               bus.in_ready, load_done, core_hold, load_err, word_cnt);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      errors++;
      $display("[TB] FAIL basic_wr_count got %0d want %0d", obs_q.size(), exp_q.size());
    end else begin
      foreach (exp_q[i]) begin
        checks++;
        if (obs_q[i] !== exp_q[i]) begin
          errors++;
          $display("[TB] FAIL basic_wr%0d got a=%h d=%h c=%0d want a=%h d=%h c=%0d", i,
                   obs_q[i].addr, obs_q[i].data, obs_q[i].cyc,
                   exp_q[i].addr, exp_q[i].data, exp_q[i].cyc);
        end
      end
    end
    checks++;
    if (bus.ram_waddr !== BASE + 32'd4 || bus.ram_wdata !== 32'h0010_0093) begin
      errors++;
      $display("[TB] FAIL basic_hold got a=%h d=%h want a=%h d=00100093",
               bus.ram_waddr, bus.ram_wdata, BASE + 32'd4);
    end
  endtask

  task automatic test_zero_len();
    apply_reset();
    img_w.delete();
    build_image(32'd0, 32'd0);
    send_bytes(tx_q.size(), 0, 0);
    @(negedge clk);
    bus.in_valid = 1'b0;
    checks++;
    if (load_done !== 1'b1 || core_hold !== 1'b0 || bus.in_ready !== 1'b0 || word_cnt !== '0) begin
      errors++;
      $display("[TB] FAIL zero_status got done=%b hold=%b rdy=%b cnt=%0d want 1 0 0 0",
               load_done, core_hold, bus.in_ready, word_cnt);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (obs_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL zero_writes got %0d want 0", obs_q.size());
    end
  endtask

  task automatic test_len_limits();
    int hs_cnt;
    apply_reset();
    img_w.delete();
    build_image(32'(MAXW), 32'd0);
    send_bytes(4, 0, 0);
    @(negedge clk);
    bus.in_valid = 1'b0;
    checks++;
    if (bus.in_ready !== 1'b1 || load_err !== 1'b0 || load_done !== 1'b0) begin
      errors++;
      $display("[TB] FAIL len_max_accept got rdy=%b err=%b done=%b want 1 0 0",
               bus.in_ready, load_err, load_done);
    end
    apply_reset();
    build_image(32'(MAXW + 1), 32'd0);
    send_bytes(4, 0, 0);
    @(negedge clk);
    bus.in_valid = 1'b0;
    checks++;
    if (load_err !== 1'b1 || load_done !== 1'b0 || bus.in_ready !== 1'b0 || core_hold !== 1'b1) begin
      errors++;
      $display("[TB] FAIL len_over_status got err=%b done=%b rdy=%b hold=%b want 1 0 0 1",
               load_err, load_done, bus.in_ready, core_hold);
    end
    hs_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.in_data  = 8'(i + 1);
      if (bus.in_ready === 1'b1) hs_cnt++;
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    checks++;
    if (hs_cnt != 0 || obs_q.size() != 0 || load_err !== 1'b1) begin
      errors++;
      $display("[TB] FAIL len_over_ignore got hs=%0d writes=%0d err=%b want 0 0 1",
               hs_cnt, obs_q.size(), load_err);
    end
  endtask

  task automatic test_gaps();
    int hs_cnt;
    apply_reset();
    img_w = '{32'h0000_0013, 32'h0010_0093};
    build_image(32'd2, 32'd0);
    send_bytes(tx_q.size(), 3, 2);
    hs_cnt = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.in_data  = 8'hA5;
      if (bus.in_ready === 1'b1) hs_cnt++;
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (hs_cnt != 0 || load_done !== 1'b1 || word_cnt !== CW'(2)) begin
      errors++;
      $display("[TB] FAIL gaps_after_done got hs=%0d done=%b cnt=%0d want 0 1 2", hs_cnt, load_done, word_cnt);
    end
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      errors++;
      $display("[TB] FAIL gaps_wr_count got %0d want %0d", obs_q.size(), exp_q.size());
    end else begin
      foreach (exp_q[i]) begin
        checks++;
        if (obs_q[i] !== exp_q[i]) begin
          errors++;
          $display("[TB] FAIL gaps_wr%0d got a=%h d=%h c=%0d want a=%h d=%h c=%0d", i,
                   obs_q[i].addr, obs_q[i].data, obs_q[i].cyc,
                   exp_q[i].addr, exp_q[i].data, exp_q[i].cyc);
        end
      end
    end
  endtask

  task automatic test_mid_reset();
    apply_reset();
    img_w = '{32'h0000_0013, 32'h0010_0093};
    build_image(32'd2, 32'd0);
    send_bytes(6, 0, 2);
    @(negedge clk);
    rst = 1'b0;
    bus.in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (bus.in_ready !== 1'b0 || bus.ram_we !== 1'b0 || core_hold !== 1'b1 || load_done !== 1'b0 ||
        load_err !== 1'b0 || word_cnt !== '0 || bus.ram_waddr !== BASE || bus.ram_wdata !== 32'd0) begin
      errors++;
      $display("[TB] FAIL midrst_values got rdy=%b we=%b hold=%b done=%b err=%b cnt=%0d a=%h d=%h want reset values",
               bus.in_ready, bus.ram_we, core_hold, load_done, load_err, word_cnt, bus.ram_waddr, bus.ram_wdata);
    end
    exp_q.delete();
    obs_q.delete();
    rst = 1'b1;
    send_bytes(tx_q.size(), 1, 2);
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (load_done !== 1'b1 || word_cnt !== CW'(2) || obs_q.size() != exp_q.size()) begin
      errors++;
      $display("[TB] FAIL midrst_reload got done=%b cnt=%0d writes=%0d want 1 2 %0d",
               load_done, word_cnt, obs_q.size(), exp_q.size());
    end else begin
      foreach (exp_q[i]) begin
        checks++;
        if (obs_q[i] !== exp_q[i]) begin
          errors++;
          $display("[TB] FAIL midrst_wr%0d got a=%h d=%h c=%0d want a=%h d=%h c=%0d", i,
                   obs_q[i].addr, obs_q[i].data, obs_q[i].cyc,
                   exp_q[i].addr, exp_q[i].data, exp_q[i].cyc);
        end
      end
    end
  endtask

`ifdef LOADER_CHECKSUM_EN
  task automatic test_checksum_bad();
    apply_reset();
    img_w = '{32'h0000_0013, 32'h0010_0093};
    build_image(32'd2, 32'd1);
    send_bytes(tx_q.size(), 0, 2);
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (load_err !== 1'b1 || load_done !== 1'b0 || core_hold !== 1'b1 || bus.in_ready !== 1'b0) begin
      errors++;
      $display("[TB] FAIL sum_bad_status got err=%b done=%b hold=%b rdy=%b want 1 0 1 0",
               load_err, load_done, core_hold, bus.in_ready);
    end
    checks++;
    if (obs_q.size() != 2 || exp_q.size() != 2) begin
      errors++;
      $display("[TB] FAIL sum_bad_writes got %0d want 2", obs_q.size());
    end else begin
      foreach (exp_q[i]) begin
        checks++;
        if (obs_q[i] !== exp_q[i]) begin
          errors++;
          $display("[TB] FAIL sum_bad_wr%0d got a=%h d=%h want a=%h d=%h", i,
                   obs_q[i].addr, obs_q[i].data, exp_q[i].addr, exp_q[i].data);
        end
      end
    end
  endtask
`endif

  initial begin
    bus.in_valid = 1'b0;
    bus.in_data  = 8'd0;
    test_reset();
    test_basic();
    test_zero_len();
    test_len_limits();
    test_gaps();
    test_mid_reset();
`ifdef LOADER_CHECKSUM_EN
    test_checksum_bad();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
